ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Multi-cycle RV32M/RV64M execute unit. Sits beside the combinational EX ALU and takes MUL/DIV/REM class ops that the ALU cannot finish in one cycle.
- Width-parametrised multiply with configurable latency; iterative radix-2 divider with RISC-V corner-case semantics.
- Valid/ready handshake on both sides, synchronous flush for branch mispredict.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LATENCY, 2, cycles from accept to result for multiply ops (1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  abort the in-flight op (mispredict).
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  in  XLEN  operand 1.
- rs2_data  in  XLEN  operand 2.
- rd_addr_i  in  5  destination register.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- rd_data  out  XLEN  result.
- rd_addr_o  out  5  destination of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state IDLE. out_valid=0, rd_data=0, rd_addr_o=0, busy=0, in_ready=1 after release.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept: in_valid && in_ready. in_ready=1 only in IDLE. Operands, op and rd_addr are latched on accept.
- IDLE to MUL for op 0-3. The multiplier counts MUL_LATENCY-1 more cycles, then goes to DONE, so out_valid rises exactly MUL_LATENCY cycles after the accept cycle.
- Multiply width rules: a 2*XLEN product is formed.
  - MUL returns the low XLEN bits.
  - MULH returns the high half, signed x signed.
  - MULHSU returns the high half, signed rs1 x unsigned rs2.
  - MULHU returns the high half, unsigned x unsigned.
- IDLE to DIV for op 4-7, with these special cases:
  - Divisor == 0 goes straight to DONE; out_valid rises 1 cycle after accept. Quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones, op 4/6) goes straight to DONE, 1 cycle. Quotient = rs1; remainder = 0.
- Normal divide:
  - Magnitudes are taken for signed ops.
  - XLEN restoring iterations, one quotient bit per cycle, with an iteration counter of clog2(XLEN)+1 bits.
  - Then FIX: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Then DONE. out_valid rises XLEN+2 cycles after accept (34 for XLEN=32).
- DONE: out_valid=1; rd_data and rd_addr_o are held stable until out_valid && out_ready, then IDLE.
  - in_ready is 0 in the handoff cycle, so there is no back-to-back accept in the same cycle.
- Flush:
  - Synchronous, highest priority in every state: next state is IDLE and out_valid=0 next cycle.
  - A request presented in the flush cycle is not accepted.
- Simultaneous in_valid and flush in IDLE: flush wins and nothing is latched.
- rst asserted mid-operation: immediate return to the reset values; no partial result is ever presented.
- rd_data is don't-care while out_valid=0 but must not change during DONE.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: on an unsigned or magnitude compare where |rs1| < |rs2| for a divide op, the unit goes straight to FIX.
  - Quotient = 0, remainder = rs1 (sign rules still apply).
  - out_valid rises 2 cycles after accept.
- Undefined: the full XLEN+2 latency always applies; results are identical either way.

Test Plan:
- XLEN=32, MUL_LATENCY=2, MUL 0x00000007 x 0xFFFFFFFD → rd_data=0xFFFFFFEB, out_valid exactly 2 cycles after accept; MULHU of the same operands → 0x00000006.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 → rd_data=0xFFFFFFFD (-3) at 34 cycles; REM of the same operands → 0xFFFFFFFF (-1).
- DIVU 0x12345678 / 0 → 0xFFFFFFFF after 1 cycle; REMU 0x12345678 / 0 → 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0x00000000; both 1-cycle latency.
- Start DIVU, hold out_ready=0 for 5 cycles at DONE → rd_data/rd_addr_o stable, in_ready=0; then out_ready=1 → IDLE next cycle, in_ready=1.
- Assert flush at iteration 10 of a DIV → out_valid never rises, busy=0 next cycle. Assert rst mid-MUL → all outputs 0 immediately. With MULDIV_EARLY_OUT_EN, DIVU 3/10 → q=0 at 2 cycles.

Source files
------------

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide execute unit with valid/ready on both sides.
// Optional MULDIV_EARLY_OUT_EN: skip the divide iterations when |dividend| < |divisor|.
//   IDLE | waiting for a request
//   MUL  | multiply latency countdown
//   DIV  | restoring divide, one quotient bit per cycle
//   FIX  | apply quotient/remainder signs
//   DONE | result presented until taken
module ex_muldiv #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_data,
    output logic [4:0]      rd_addr_o,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic            accept;
    logic [XLEN-1:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [XLEN:0]   trial, diff;

    function automatic logic [XLEN-1:0] mul_result(input logic [2:0] f,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ae, be, p;
        ae = {{XLEN{(f != 3'd3) && a[XLEN-1]}}, a};
        be = {{XLEN{(f == 3'd1) && b[XLEN-1]}}, b};
        p  = ae * be;
        return (f[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign in_ready  = (state_q == S_IDLE) && !flush && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign rd_data   = result_q;
    assign rd_addr_o = rd_addr_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_addr_d = rd_addr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        accept  = in_valid && in_ready;
        abs_a   = (!op[0] && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        abs_b   = (!op[0] && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
        trial   = {rem_q, opa_q[XLEN-1]};
        diff    = trial - {1'b0, opb_q};
        quo_fix = neg_quo_q ? -opa_q : opa_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = op;
                    rd_addr_d = rd_addr_i;
                    opa_d     = rs1_data;
                    opb_d     = rs2_data;
                    if (!op[2]) begin
                        if (MUL_LATENCY == 1) begin
                            result_d = mul_result(op, rs1_data, rs2_data);
                            state_d  = S_DONE;
                        end else begin
                            cnt_d   = CW'(MUL_LATENCY - 1);
                            state_d = S_MUL;
                        end
                    end else if (rs2_data == '0) begin
                        result_d = op[1] ? rs1_data : '1;
                        state_d  = S_DONE;
                    end else if (!op[0] && rs1_data == MIN_NEG && rs2_data == '1) begin
                        result_d = op[1] ? '0 : rs1_data;
                        state_d  = S_DONE;
                    end else begin
                        // opa holds the dividend magnitude; quotient bits shift in from the right
                        neg_quo_d = !op[0] && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
                        neg_rem_d = !op[0] && rs1_data[XLEN-1];
                        opa_d     = abs_a;
                        opb_d     = abs_b;
                        rem_d     = '0;
                        cnt_d     = CW'(XLEN);
                        state_d   = S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
                        if (abs_a < abs_b) begin
                            opa_d   = '0;
                            rem_d   = abs_a;
                            state_d = S_FIX;
                        end
`endif
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(1)) begin
                    result_d = mul_result(op_q, opa_q, opb_q);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    opa_d = {opa_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = trial[XLEN-1:0];
                    opa_d = {opa_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_addr_q <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_addr_q <= rd_addr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32, MUL_LATENCY=2): directed table, corner sequences, random vs model.
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam int MLAT = 2;
    localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr_o;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    ex_muldiv #(.XLEN(XLEN), .MUL_LATENCY(MLAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_i(rd_addr_i),
        .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data),
        .rd_addr_o(rd_addr_o), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the RISC-V M rules
    function automatic logic [31:0] ref_data(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb;
        if (o < 3'd4) return MLAT;
        if (b == 0) return 1;
        if (!o[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = o[0] ? longint'({32'b0, a}) : (sa < 0 ? -sa : sa);
        mb = o[0] ? longint'({32'b0, b}) : (sb < 0 ? -sb : sb);
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`else
        if (ma < mb) return XLEN + 2;
`endif
        return XLEN + 2;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_issue", in_ready, 1);
        in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr_i = rd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(o, a, b, rd);
        wait_result(lat);
        check($sformatf("%s_lat", name), lat, exp_lat);
        check($sformatf("%s_data", name), rd_data, exp);
        check($sformatf("%s_rd", name), rd_addr_o, rd);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[16];

    initial begin
        int lat, quiet;
        logic [31:0] a, b;
        logic [2:0]  o;
        logic [4:0]  rd;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 2};
        vecs[2]  = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[7]  = '{3'd7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1};
        vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[10] = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[11] = '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1};
        vecs[12] = '{3'd5, 32'h0000_0003, 32'h0000_000A, 32'h0000_0000, EO_LAT};
        vecs[13] = '{3'd7, 32'h0000_0003, 32'h0000_000A, 32'h0000_0003, EO_LAT};
        vecs[14] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[15] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat);

        // DONE held with out_ready low
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 5'd9);
        wait_result(lat);
        check("hold_lat", lat, 34);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", rd_data, 32'd14);
            check("hold_rd", rd_addr_o, 5'd9);
            check("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("handoff_in_ready", in_ready, 0);
        check("handoff_valid", out_valid, 1);
        @(negedge clk);
        check("after_handoff_valid", out_valid, 0);
        check("after_handoff_in_ready", in_ready, 1);
        check("after_handoff_busy", busy, 0);

        // flush at iteration 10 of a divide
        issue(3'd4, 32'd1000, 32'd3, 5'd4);
        repeat (9) @(negedge clk);
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", busy, 0);
        quiet = 1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) quiet = 0;
            @(negedge clk);
        end
        check("flush_no_valid", quiet, 1);

        // request in the flush cycle is dropped
        in_valid = 1'b1; op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4; rd_addr_i = 5'd7;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", busy, 0);
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || busy) quiet = 0;
            @(negedge clk);
        end
        check("flush_idle_no_accept", quiet, 1);

        // reset mid-multiply
        issue(3'd0, 32'd6, 32'd7, 5'd5);
        check("mid_mul_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_rd", rd_addr_o, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        quiet = 1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) quiet = 0;
            @(negedge clk);
        end
        check("mid_rst_no_partial", quiet, 1);

        // random operations against the reference model
        for (int i = 0; i < 200; i++) begin
            o  = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            rd = 5'($urandom);
            run_op($sformatf("rnd%0d_op%0d_%h_%h", i, o, a, b), o, a, b, rd,
                   ref_data(o, a, b), ref_lat(o, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
